id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RV64 core, with integrated load-use hazard detection.
- Sits directly upstream of the forwarding unit and EX stage; supplies the ID_EX_Rs1/Rs2/Rd and control fields the forwarding unit compares against EX/MEM and MEM/WB.
- Inserts bubbles on load-use hazards and branch flushes, holds on downstream back-pressure, and bypasses same-cycle WB writes into captured operands.

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage RV64 core with integrated load-use
//   hazard detection. Inserts bubbles on load-use hazards and EX branch
//   flushes, freezes on downstream back-pressure, and bypasses a same-cycle
//   WB register write into the captured operands.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   id_*                            decoded instruction and operands from ID
//   wb_reg_write, wb_rd, wb_data    MEM/WB writeback, used for operand bypass
//   ex_flush                        branch taken in EX, squash ID instruction
//   mem_hold                        downstream stall, freeze ID/EX
//   ID_EX_*                         registered fields for forwarding unit / EX
//   pc_write, if_id_write           combinational; 0 freezes PC / IF/ID
//   stall_count                     saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             id_alu_src,
    input  logic [1:0]       id_alu_op,

    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,

    input  logic             ex_flush,
    input  logic             mem_hold,

    output logic             ID_EX_valid,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [XLEN-1:0]  ID_EX_rs1_data,
    output logic [XLEN-1:0]  ID_EX_rs2_data,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic [4:0]       ID_EX_Rs1,
    output logic [4:0]       ID_EX_Rs2,
    output logic [4:0]       ID_EX_Rd,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic             ID_EX_MemWrite,
    output logic             ID_EX_MemToReg,
    output logic             ID_EX_Branch,
    output logic             ID_EX_ALUSrc,
    output logic [1:0]       ID_EX_ALUOp,

    output logic             pc_write,
    output logic             if_id_write,
    output logic [CNT_W-1:0] stall_count
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Register file is read in ID while WB writes in the same cycle; pick up
    // the in-flight value so EX never sees a stale operand. x0 is hardwired.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_we,
        input logic [4:0]      wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        return (wb_we && (wb_idx != 5'd0) && (wb_idx == rs)) ? wb_val : rf_data;
    endfunction

    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic ctrl_en;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ID_EX_Rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ID_EX_Rd);
    assign load_use = ID_EX_valid && ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      id_valid && (rs1_hit || rs2_hit);

    // A flush squashes the dependent instruction anyway, so the front end
    // must keep advancing toward the branch target rather than freeze.
    assign pc_write    = ~(mem_hold | (load_use & ~ex_flush));
    assign if_id_write = pc_write;

    // An invalid ID slot must not carry side effects into EX.
    assign ctrl_en = id_valid;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_Rs1      <= '0;
            ID_EX_Rs2      <= '0;
            ID_EX_Rd       <= '0;
            ID_EX_RegWrite <= 1'b0;
            ID_EX_MemRead  <= 1'b0;
            ID_EX_MemWrite <= 1'b0;
            ID_EX_MemToReg <= 1'b0;
            ID_EX_Branch   <= 1'b0;
            ID_EX_ALUSrc   <= 1'b0;
            ID_EX_ALUOp    <= '0;
            stall_count    <= '0;
        end else if (mem_hold) begin
            // Freeze: every field keeps its value; flush/hazard wait.
        end else if (ex_flush || load_use) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_Rs1      <= '0;
            ID_EX_Rs2      <= '0;
            ID_EX_Rd       <= '0;
            ID_EX_RegWrite <= 1'b0;
            ID_EX_MemRead  <= 1'b0;
            ID_EX_MemWrite <= 1'b0;
            ID_EX_MemToReg <= 1'b0;
            ID_EX_Branch   <= 1'b0;
            ID_EX_ALUSrc   <= 1'b0;
            ID_EX_ALUOp    <= '0;
            // Only a hazard bubble counts; a flush outranks the hazard.
            if (!ex_flush) begin
                stall_count <= sat_inc(stall_count);
            end
        end else begin
            ID_EX_valid    <= id_valid;
            ID_EX_pc       <= id_pc;
            ID_EX_rs1_data <= wb_bypass(id_rs1, id_rs1_data, wb_reg_write, wb_rd, wb_data);
            ID_EX_rs2_data <= wb_bypass(id_rs2, id_rs2_data, wb_reg_write, wb_rd, wb_data);
            ID_EX_imm      <= id_imm;
            ID_EX_Rs1      <= id_rs1;
            ID_EX_Rs2      <= id_rs2;
            ID_EX_Rd       <= id_rd;
            ID_EX_RegWrite <= ctrl_en & id_reg_write;
            ID_EX_MemRead  <= ctrl_en & id_mem_read;
            ID_EX_MemWrite <= ctrl_en & id_mem_write;
            ID_EX_MemToReg <= ctrl_en & id_mem_to_reg;
            ID_EX_Branch   <= ctrl_en & id_branch;
            ID_EX_ALUSrc   <= ctrl_en & id_alu_src;
            ID_EX_ALUOp    <= id_alu_op;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed scoreboard bench for id_ex_stage. The driver applies one vector
//   per cycle on the falling edge and queues the hand-computed state expected
//   after the next rising edge (plus the pre-edge pc_write). A separate
//   monitor pops and compares. The counter is built 3 bits wide so that
//   saturation is reachable with a short run of hazards.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam int XLEN  = 64;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src;
    logic [1:0]       id_alu_op;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             ex_flush, mem_hold;
    logic             ID_EX_valid;
    logic [XLEN-1:0]  ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]       ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
    logic             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_Branch, ID_EX_ALUSrc;
    logic [1:0]       ID_EX_ALUOp;
    logic             pc_write, if_id_write;
    logic [CNT_W-1:0] stall_count;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .mem_hold(mem_hold),
        .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data),
        .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
        .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_ALUOp(ID_EX_ALUOp),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic             v;
        logic [XLEN-1:0]  pc, r1, r2;
        logic [4:0]       rd;
        logic             rw, mr, pcw;
        logic [CNT_W-1:0] st;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vid      = 0;

    task automatic chk(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec%0d got=%0h exp=%0h", nm, id, got, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_branch = 0; id_alu_src = 0; id_alu_op = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = '0; ex_flush = 0; mem_hold = 0;
    endtask

    // ld x5, 0(x2)
    task automatic set_ld(input logic [XLEN-1:0] pc);
        clr();
        id_valid = 1; id_pc = pc; id_rd = 5; id_rs1 = 2; id_uses_rs1 = 1;
        id_rs1_data = 64'h11; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1;
    endtask

    // add x6, x5, x7
    task automatic set_add(input logic [XLEN-1:0] pc);
        clr();
        id_valid = 1; id_pc = pc; id_rs1 = 5; id_rs2 = 7; id_uses_rs1 = 1; id_uses_rs2 = 1;
        id_rd = 6; id_reg_write = 1; id_rs1_data = 64'h22; id_rs2_data = 64'h77; id_alu_op = 2'd2;
    endtask

    // Queue the expectation for the current inputs, then advance one cycle.
    task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] r1,
                        input logic [XLEN-1:0] r2, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic pcw, input logic [CNT_W-1:0] st);
        exp_t e;
        e.id = vid; e.v = v; e.pc = pc; e.r1 = r1; e.r2 = r2; e.rd = rd;
        e.rw = rw; e.mr = mr; e.pcw = pcw; e.st = st;
        sb.push_back(e);
        vid++;
        @(negedge clk);
    endtask

    // Monitor: pc_write is sampled late in the low phase, registers just after the edge.
    initial begin : monitor
        logic pcw_s, ifw_s;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            pcw_s = pc_write;
            ifw_s = if_id_write;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_write",    e.id, 64'(pcw_s),          64'(e.pcw));
                chk("if_id_write", e.id, 64'(ifw_s),          64'(e.pcw));
                chk("valid",       e.id, 64'(ID_EX_valid),    64'(e.v));
                chk("pc",          e.id, ID_EX_pc,            e.pc);
                chk("rs1_data",    e.id, ID_EX_rs1_data,      e.r1);
                chk("rs2_data",    e.id, ID_EX_rs2_data,      e.r2);
                chk("rd",          e.id, 64'(ID_EX_Rd),       64'(e.rd));
                chk("reg_write",   e.id, 64'(ID_EX_RegWrite), 64'(e.rw));
                chk("mem_read",    e.id, 64'(ID_EX_MemRead),  64'(e.mr));
                chk("stall_count", e.id, 64'(stall_count),    64'(e.st));
            end
        end
    end

    initial begin : driver
        logic [CNT_W-1:0] cnt;
        rst_n = 0;
        clr();
        // Reset with inputs toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id_valid = 1'($urandom); id_pc = {$urandom, $urandom}; id_rd = 5'($urandom);
            id_reg_write = 1; id_mem_read = 1'($urandom); id_rs1_data = {$urandom, $urandom};
            ex_flush = 1'($urandom);
        end
        #1;
        chk("rst_valid", -1, 64'(ID_EX_valid), 64'd0);
        chk("rst_pc",    -1, ID_EX_pc, 64'd0);
        chk("rst_rd",    -1, 64'(ID_EX_Rd), 64'd0);
        chk("rst_rw",    -1, 64'(ID_EX_RegWrite), 64'd0);
        chk("rst_rs1",   -1, ID_EX_rs1_data, 64'd0);
        chk("rst_stall", -1, 64'(stall_count), 64'd0);

        @(negedge clk);
        clr(); rst_n = 1;
        id_valid = 1; id_pc = 64'h100; id_rd = 5;
        step(1, 64'h100, 0, 0, 5, 0, 0, 1, 0);

        // Load-use: ld x5 then add x6,x5,x7 -> one bubble, then add enters.
        set_ld(64'h104);
        step(1, 64'h104, 64'h11, 0, 5, 1, 1, 1, 0);
        set_add(64'h108);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 64'h108, 64'h22, 64'h77, 6, 1, 0, 1, 1);

        // Same hazard with a flush: bubble, PC keeps moving, no count.
        set_ld(64'h10C);
        step(1, 64'h10C, 64'h11, 0, 5, 1, 1, 1, 1);
        set_add(64'h110); ex_flush = 1;
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Hold 3 cycles with flush pending, then the flush lands.
        clr(); id_valid = 1; id_pc = 64'h200; id_rd = 9; id_rs1 = 1; id_uses_rs1 = 1;
        id_rs1_data = 64'h33; id_reg_write = 1;
        step(1, 64'h200, 64'h33, 0, 9, 1, 0, 1, 1);
        set_add(64'h300); mem_hold = 1; ex_flush = 1;
        repeat (3) step(1, 64'h200, 64'h33, 0, 9, 1, 0, 0, 1);
        mem_hold = 0;
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // WB bypass on both operands, then x0 and disabled-write cases.
        clr(); id_valid = 1; id_pc = 64'h400; id_rs1 = 3; id_rs2 = 3; id_rs1_data = 64'h1;
        id_rs2_data = 64'h2; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rd = 4; id_reg_write = 1;
        wb_reg_write = 1; wb_rd = 3; wb_data = 64'hDEAD;
        step(1, 64'h400, 64'hDEAD, 64'hDEAD, 4, 1, 0, 1, 1);
        wb_rd = 0; id_rs1 = 0; id_rs2 = 0;
        step(1, 64'h400, 64'h1, 64'h2, 4, 1, 0, 1, 1);
        wb_rd = 3; wb_reg_write = 0; id_rs1 = 3; id_rs2 = 3;
        step(1, 64'h400, 64'h1, 64'h2, 4, 1, 0, 1, 1);
        wb_reg_write = 1; id_rs2 = 8;
        step(1, 64'h400, 64'hDEAD, 64'h2, 4, 1, 0, 1, 1);

        // Invalid slot drops control; the following reader of x5 does not stall.
        clr(); id_valid = 0; id_pc = 64'h500; id_rd = 5; id_reg_write = 1; id_mem_read = 1;
        id_mem_to_reg = 1; id_branch = 1;
        step(0, 64'h500, 0, 0, 5, 0, 0, 1, 1);
        set_add(64'h504);
        step(1, 64'h504, 64'h22, 64'h77, 6, 1, 0, 1, 1);

        // Load to x0 never stalls.
        set_ld(64'h600); id_rd = 0;
        step(1, 64'h600, 64'h11, 0, 0, 1, 1, 1, 1);
        set_add(64'h604); id_rs1 = 0; id_rs2 = 0;
        step(1, 64'h604, 64'h22, 64'h77, 6, 1, 0, 1, 1);

        // Saturation: 8 more hazards on a 3-bit counter, 1 -> 7 and stays.
        cnt = 1;
        for (int i = 0; i < 8; i++) begin
            set_ld(64'h700 + 64'(i * 8));
            step(1, 64'h700 + 64'(i * 8), 64'h11, 0, 5, 1, 1, 1, cnt);
            set_add(64'h704 + 64'(i * 8));
            cnt = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
            step(0, 0, 0, 0, 0, 0, 0, 0, cnt);
        end

        // Reset asserted mid-stall clears immediately; release captures normally.
        set_ld(64'h800);
        step(1, 64'h800, 64'h11, 0, 5, 1, 1, 1, 3'd7);
        set_add(64'h808);
        #2;
        chk("midstall_pcw", -2, 64'(pc_write), 64'd0);
        rst_n = 0;
        #1;
        chk("midrst_valid", -2, 64'(ID_EX_valid), 64'd0);
        chk("midrst_mr",    -2, 64'(ID_EX_MemRead), 64'd0);
        chk("midrst_stall", -2, 64'(stall_count), 64'd0);
        chk("midrst_pcw",   -2, 64'(pc_write), 64'd1);
        @(negedge clk);
        rst_n = 1;
        step(1, 64'h808, 64'h22, 64'h77, 6, 1, 0, 1, 0);

        @(posedge clk);
        #2;
        chk("drain", -3, 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global safety bound.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
